rom_access_arbiter: RTL and testbench

//  Shares one ROM_sync instance (1-cycle registered read) between NUM_REQ requesters
//  (e.g. instruction fetch, constant load) using round-robin arbitration.

---
 rtl/rom_access_arbiter_if.sv | 31 +++
 rtl/rom_access_arbiter.sv | 118 +++++++++++
 tb/tb_rom_access_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_access_arbiter_if.sv
// Request/response bus between requesters and the shared ROM arbiter, plus the ROM read port.
// Latency: n/a (wiring only).
// Backpressure: req_ready is the only flow-control signal; responses cannot be stalled.
interface rom_access_arbiter_if #(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_data;
  logic                             rsp_error;
  logic                             busy;
  logic                             rom_read_enable;
  logic [ADDRESS_WIDTH-1:0]         rom_address;
  logic [DATA_WIDTH-1:0]            rom_data;

  // Requesters and the ROM sit on this side
  modport master (
    output req_valid, req_address, rom_data,
    input  req_ready, rsp_valid, rsp_data, rsp_error, busy, rom_read_enable, rom_address
  );

  // The arbiter sits on this side
  modport slave (
    input  req_valid, req_address, rom_data,
    output req_ready, rsp_valid, rsp_data, rsp_error, busy, rom_read_enable, rom_address
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between NUM_REQ requesters; flags out-of-range reads.
// Latency: accept in cycle T -> rsp_valid in T+3 (in range) or T+1 (out of range).
// Backpressure: req_ready only in IDLE, one-hot to the round-robin winner; no request queueing.
module rom_access_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int MEMORY_DEPTH  = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  rom_access_arbiter_if.slave   bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so a depth of exactly 2**ADDRESS_WIDTH still compares correctly
  localparam logic [ADDRESS_WIDTH:0] LP_DEPTH = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [GW-1:0]          LP_LAST  = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_RESP} state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [GW-1:0]            r_last_grant;
  logic [GW-1:0]            r_grant;
  logic [GW-1:0]            w_winner;
  logic                     w_any;
  logic                     w_accept;
  logic                     w_addr_err;
  logic [NUM_REQ-1:0]       w_onehot;
  logic [ADDRESS_WIDTH-1:0] w_req_addr;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_error;

  // Round-robin search starting just after the last grant, wrapping around
  always_comb begin
    logic [GW-1:0] v_idx;
    w_winner = r_last_grant;
    w_any    = 1'b0;
    v_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_any && bus.req_valid[v_idx]) begin
        w_any    = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // Winner one-hot and its address slice, with range check
  always_comb begin
    w_onehot   = '0;
    w_req_addr = '0;
    if (w_any) w_onehot[w_winner] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == GW'(i)) w_req_addr = bus.req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end
    w_addr_err = ({1'b0, w_req_addr} >= LP_DEPTH);
    w_accept   = (r_state == S_IDLE) && w_any;
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state: errors skip the ROM and go straight to the response
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = w_addr_err ? S_RESP : S_READ;
      S_READ:    w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_RESP;
      S_RESP:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: handshake, strobes and ROM port
  always_comb begin
    bus.req_ready       = (r_state == S_IDLE) ? w_onehot : '0;
    bus.rsp_valid       = '0;
    if (r_state == S_RESP) bus.rsp_valid[r_grant] = 1'b1;
    bus.busy            = (r_state != S_IDLE);
    bus.rom_read_enable = (r_state == S_READ);
    bus.rom_address     = r_addr;
    bus.rsp_data        = r_rsp_data;
    bus.rsp_error       = r_rsp_error;
  end

  // Datapath: latch grant/address on accept, capture ROM data or force the error response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= LP_LAST;
      r_grant      <= '0;
      r_addr       <= '0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant      <= w_winner;
        r_last_grant <= w_winner;
        if (w_addr_err) begin
          r_rsp_data  <= '0;
          r_rsp_error <= 1'b1;
        end else begin
          // ROM address only moves for real reads so it holds across error accesses
          r_addr <= w_req_addr;
        end
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_data  <= bus.rom_data;
        r_rsp_error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rom_access_arbiter.sv
module tb_rom_access_arbiter;
  localparam int NR = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MD = 64;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DW-1:0] rom [0:255];

  rom_access_arbiter_if #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  rom_access_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_DEPTH(MD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Synchronous ROM model: one-cycle registered read, output holds when not enabled
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 bus.rom_data <= '0;
    else if (bus.rom_read_enable) bus.rom_data <= rom[bus.rom_address];
  end

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_address = '0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.busy,
         bus.rom_read_enable, bus.rom_address} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.req_ready, bus.rsp_valid, bus.rsp_data,
               bus.rsp_error, bus.busy, bus.rom_read_enable, bus.rom_address});
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_oh;
    logic [7:0] exp_d, exp_a;
    @(negedge clock);
    bus.req_valid = 2'b11;
    bus.req_address = {8'd2, 8'd1};
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      exp_oh = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      exp_d  = ((c / 4) % 2 == 0) ? 8'h11 : 8'h22;
      exp_a  = ((c / 4) % 2 == 0) ? 8'd1 : 8'd2;
      n_checks++;
      case (c % 4)
        0: if ({bus.req_ready, bus.busy} !== {exp_oh, 1'b0}) begin
             n_fail++;
             $display("FAIL rr_grant c=%0d got=%b/%b exp=%b/0", c, bus.req_ready, bus.busy, exp_oh);
           end
        1: if ({bus.rom_read_enable, bus.rom_address, bus.req_ready} !== {1'b1, exp_a, 2'b00}) begin
             n_fail++;
             $display("FAIL rr_read c=%0d got=%b/%h/%b exp=1/%h/00", c, bus.rom_read_enable,
                      bus.rom_address, bus.req_ready, exp_a);
           end
        2: if ({bus.rom_read_enable, bus.rsp_valid} !== 3'b000) begin
             n_fail++;
             $display("FAIL rr_capture c=%0d got=%b/%b exp=0/00", c, bus.rom_read_enable, bus.rsp_valid);
           end
        default: if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error} !== {exp_oh, exp_d, 1'b0}) begin
             n_fail++;
             $display("FAIL rr_resp c=%0d got=%b/%h/%b exp=%b/%h/0", c, bus.rsp_valid, bus.rsp_data,
                      bus.rsp_error, exp_oh, exp_d);
           end
      endcase
      if (c == 15) bus.req_valid = '0;
    end
  endtask

  task automatic test_single_read();
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.req_address = {8'd0, 8'd5};
    #1;
    n_checks++;
    if ({bus.req_ready, bus.busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL single_ready got=%b/%b exp=01/0", bus.req_ready, bus.busy);
    end
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    n_checks++;
    if ({bus.rom_read_enable, bus.rom_address, bus.busy, bus.req_ready} !== {1'b1, 8'd5, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL single_read got=%b/%h/%b/%b exp=1/05/1/00", bus.rom_read_enable, bus.rom_address,
               bus.busy, bus.req_ready);
    end
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rom_read_enable} !== {2'b01, 8'hA5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_resp got=%b/%h/%b/%b exp=01/a5/0/0", bus.rsp_valid, bus.rsp_data,
               bus.rsp_error, bus.rom_read_enable);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.busy, bus.rsp_data, bus.rom_address} !== {2'b00, 1'b0, 8'hA5, 8'd5}) begin
      n_fail++;
      $display("FAIL single_hold got=%b/%b/%h/%h exp=00/0/a5/05", bus.rsp_valid, bus.busy,
               bus.rsp_data, bus.rom_address);
    end
  endtask

  task automatic test_range_boundary();
    // Last valid word (63) from requester 1: normal read, ROM[63] = 0x3f ^ 0x3c = 0x03
    @(negedge clock);
    bus.req_valid = 2'b10;
    bus.req_address = {8'd63, 8'd0};
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL edge63_ready got=%b exp=10", bus.req_ready);
    end
    @(negedge clock);
    bus.req_valid = '0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error} !== {2'b10, 8'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL edge63_resp got=%b/%h/%b exp=10/03/0", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
    end
    // First invalid word (64) from requester 0, held for two back-to-back error accesses
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.req_address = {8'd0, 8'd64};
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL err_ready got=%b exp=01", bus.req_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_error, bus.rsp_data, bus.rom_read_enable, bus.rom_address, bus.req_ready}
          !== {2'b01, 1'b1, 8'h00, 1'b0, 8'd63, 2'b00}) begin
        n_fail++;
        $display("FAIL err_resp k=%0d got=%b/%b/%h/%b/%h/%b exp=01/1/00/0/3f/00", k, bus.rsp_valid,
                 bus.rsp_error, bus.rsp_data, bus.rom_read_enable, bus.rom_address, bus.req_ready);
      end
      if (k == 1) bus.req_valid = '0;
      else begin
        @(negedge clock);
        #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_error} !== {2'b01, 2'b00, 1'b1}) begin
          n_fail++;
          $display("FAIL err_b2b got=%b/%b/%b exp=01/00/1", bus.req_ready, bus.rsp_valid, bus.rsp_error);
        end
      end
    end
    // Top of the address space from requester 1
    @(negedge clock);
    bus.req_valid = 2'b10;
    bus.req_address = {8'hFF, 8'd0};
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_data} !== {2'b10, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL err_ff got=%b/%b/%h exp=10/1/00", bus.rsp_valid, bus.rsp_error, bus.rsp_data);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_abort();
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.req_address = {8'd0, 8'd5};
    @(negedge clock);
    bus.req_valid = '0;
    @(negedge clock);
    // In CAPTURE now; abort the access
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.busy,
         bus.rom_read_enable, bus.rom_address} !== 23'd0) begin
      n_fail++;
      $display("FAIL abort_outputs got=%h exp=0", {bus.req_ready, bus.rsp_valid, bus.rsp_data,
               bus.rsp_error, bus.busy, bus.rom_read_enable, bus.rom_address});
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_no_rsp got=%b/%b exp=00/0", bus.rsp_valid, bus.busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_address = {8'd2, 8'd1};
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_first_grant got=%b exp=01", bus.req_ready);
    end
    @(negedge clock);
    bus.req_valid = '0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, 8'h11}) begin
      n_fail++;
      $display("FAIL abort_resume got=%b/%h exp=01/11", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_no_queue();
    @(negedge clock);
    bus.req_valid = 2'b01;
    bus.req_address = {8'd2, 8'd5};
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL nq_accept got=%b exp=01", bus.req_ready);
    end
    @(negedge clock);
    bus.req_valid = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      n_checks++;
      if (bus.req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL nq_blocked c=%0d got=%b exp=00", c, bus.req_ready);
      end
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {2'b01, 8'hA5}) begin
      n_fail++;
      $display("FAIL nq_resp0 got=%b/%h exp=01/a5", bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.req_ready, bus.busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL nq_grant1 got=%b/%b exp=10/0", bus.req_ready, bus.busy);
    end
    @(negedge clock);
    bus.req_valid = '0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {2'b10, 8'h22}) begin
      n_fail++;
      $display("FAIL nq_resp1 got=%b/%h exp=10/22", bus.rsp_valid, bus.rsp_data);
    end
    // Requester 1 appears during the access and withdraws before IDLE
    @(negedge clock);
    bus.req_valid = 2'b01;
    @(negedge clock);
    bus.req_valid = 2'b10;
    @(negedge clock);
    bus.req_valid = 2'b00;
    @(negedge clock);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if ({bus.req_ready, bus.busy, bus.rsp_valid} !== 5'b00000) begin
        n_fail++;
        $display("FAIL nq_withdrawn c=%0d got=%b/%b/%b exp=00/0/00", c, bus.req_ready, bus.busy, bus.rsp_valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h3C;
    rom[1] = 8'h11;
    rom[2] = 8'h22;
    rom[5] = 8'hA5;
    test_reset();
    test_round_robin();
    test_single_read();
    test_range_boundary();
    test_reset_abort();
    test_no_queue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end
endmodule
